// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
//
// Interrupt controller that drives the VECTOR input of Core18. It collects
// NUM_IRQ asynchronous request lines and applies a per-channel enable and a
// per-channel edge/level mode. Requests are arbitrated by fixed priority,
// where the lowest channel wins. The chosen vector is held stable until the
// core acknowledges it. Channel i is reported as vector i+1, and vector 0
// means idle.
//
// Ports
//   CLK        system clock; all state changes on the rising edge
//   RESET_N    asynchronous active-low reset
//   IRQ        raw request lines, asynchronous to CLK
//   ACK        single-cycle pulse: the core has taken the presented vector
//   CFG_WR     configuration write strobe
//   CFG_ADRS   register select:
//                0 = ENABLE  (read/write)
//                1 = EDGE    (read/write)
//                2 = PENDING (read; write 1 to clear)
//                3 = SWTRIG  (write only; reads 0)
//   CFG_WDATA  configuration write data; bits above NUM_IRQ are ignored
//   CFG_RDATA  read data, combinational from CFG_ADRS, zero-extended
//   VECTOR     registered vector to the core

module irq_vector_ctrl #(
  parameter int NUM_IRQ = 15,
  parameter int VEC_W   = 4,
  parameter int DATA_W  = 18
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               ACK,
  input  logic               CFG_WR,
  input  logic [1:0]         CFG_ADRS,
  input  logic [DATA_W-1:0]  CFG_WDATA,
  output logic [DATA_W-1:0]  CFG_RDATA,
  output logic [VEC_W-1:0]   VECTOR
);

  // Every channel needs a distinct nonzero vector, and every register field
  // must fit on the configuration bus.
  generate
    if (NUM_IRQ < 1 || NUM_IRQ >= (2 ** VEC_W)) begin : g_bad_num_irq
      $error("irq_vector_ctrl: NUM_IRQ must lie in 1..(2**VEC_W)-1");
    end
    if (DATA_W < NUM_IRQ) begin : g_bad_data_w
      $error("irq_vector_ctrl: DATA_W must be at least NUM_IRQ");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_BLANK   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_s3;
  logic [NUM_IRQ-1:0] enable_q, edge_q, pending_q, pending_d;

  logic [NUM_IRQ-1:0] wdata_bits;
  logic               wr_enable, wr_edge, wr_pending, wr_swtrig;
  logic [NUM_IRQ-1:0] rise, sw_set, w1c_clr, ack_clr;
  logic [NUM_IRQ-1:0] request, present_mask;
  logic               cand_valid, present_live, ack_taken;
  logic [VEC_W-1:0]   cand_vec;

  // Write data bits above NUM_IRQ are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^CFG_WDATA;

  assign wdata_bits = CFG_WDATA[NUM_IRQ-1:0];
  assign wr_enable  = CFG_WR && (CFG_ADRS == 2'd0);
  assign wr_edge    = CFG_WR && (CFG_ADRS == 2'd1);
  assign wr_pending = CFG_WR && (CFG_ADRS == 2'd2);
  assign wr_swtrig  = CFG_WR && (CFG_ADRS == 2'd3);

  // Two-flop synchroniser plus a history flop. A rising edge is s2 & ~s3.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
      irq_s3 <= '0;
    end else begin
      irq_s1 <= IRQ;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
    end
  end

  // One-hot mask of the channel whose vector is currently presented.
  always_comb begin
    present_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      present_mask[i] = (vector_q == VEC_W'(i + 1));
    end
  end

  assign ack_taken = (state_q == ST_PRESENT) && ACK;

  // Pending update. On an edge channel, any set source wins over a clear
  // source in the same cycle, so a new edge is never lost. A level channel
  // simply follows its synchronised input.
  always_comb begin
    rise      = irq_s2 & ~irq_s3;
    sw_set    = wr_swtrig  ? wdata_bits : '0;
    w1c_clr   = wr_pending ? wdata_bits : '0;
    ack_clr   = ack_taken  ? present_mask : '0;
    pending_d = (edge_q & ((pending_q & ~(w1c_clr | ack_clr)) | rise | sw_set))
              | (~edge_q & irq_s2);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_enable) begin
        enable_q <= wdata_bits;
      end
      if (wr_edge) begin
        edge_q <= wdata_bits;
      end
    end
  end

  // Fixed-priority arbitration: the lowest enabled pending channel wins.
  // The loop runs from the top down, so the last match is the lowest index.
  always_comb begin
    request    = pending_q & enable_q;
    cand_valid = |request;
    cand_vec   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (request[i]) begin
        cand_vec = VEC_W'(i + 1);
      end
    end
    present_live = |(request & present_mask);
  end

  // A presented vector is never preempted by a higher-priority request. It
  // leaves PRESENT only on ACK, which goes through a one-cycle BLANK so the
  // core sees VECTOR fall. It also leaves when the request is withdrawn,
  // returning straight to IDLE.
  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    unique case (state_q)
      ST_IDLE: begin
        vector_d = '0;
        if (cand_valid) begin
          state_d  = ST_PRESENT;
          vector_d = cand_vec;
        end
      end
      ST_PRESENT: begin
        if (ACK) begin
          state_d  = ST_BLANK;
          vector_d = '0;
        end else if (!present_live) begin
          state_d  = ST_IDLE;
          vector_d = '0;
        end
      end
      ST_BLANK: begin
        state_d  = ST_IDLE;
        vector_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        vector_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
    end
  end

  assign VECTOR = vector_q;

  // Read mux. SWTRIG is write-only and reads as zero.
  always_comb begin
    CFG_RDATA = '0;
    unique case (CFG_ADRS)
      2'd0:    CFG_RDATA[NUM_IRQ-1:0] = enable_q;
      2'd1:    CFG_RDATA[NUM_IRQ-1:0] = edge_q;
      2'd2:    CFG_RDATA[NUM_IRQ-1:0] = pending_q;
      default: CFG_RDATA = '0;
    endcase
  end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
- Parametrised interrupt controller feeding the VECTOR input of Core18.
- Collects NUM_IRQ asynchronous request lines and applies per-channel enable and per-channel edge/level mode.
- Arbitrates by fixed priority and holds a stable nonzero vector until the core acknowledges.
- Configured through the core's port bus; generalises the single hard-wired 4-bit vector input to N channels with pending/clear/software-trigger support.

Parameters:
- NUM_IRQ, 15, number of request channels; legal range 1..(2**VEC_W)-1.
- VEC_W, 4, width of VECTOR; channel i maps to vector i+1; vector 0 means no request.
- DATA_W, 18, width of the configuration data bus.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IRQ  in  NUM_IRQ  raw request lines, asynchronous to CLK.
- ACK  in  1  single-cycle pulse from the core: the presented vector has been taken.
- CFG_WR  in  1  configuration write strobe.
- CFG_ADRS  in  2  configuration register select.
- CFG_WDATA  in  DATA_W  write data.
- CFG_RDATA  out  DATA_W  read data, combinational from CFG_ADRS.
- VECTOR  out  VEC_W  registered vector to the core; 0 means idle.

Behaviour:
- Reset (async, RESET_N low): all registers clear immediately.
  - VECTOR=0; state IDLE.
  - ENABLE=0, EDGE=0 (all channels level mode), PENDING=0.
  - Synchroniser flops = 0.
  - Reset mid-presentation drops VECTOR to 0 with no ACK required.
- Input path: per channel, 2-flop synchroniser s1,s2 plus a history flop s3.
  - rise = s2 & ~s3.
- Pending rules:
  - Edge channel (EDGE[i]=1): PENDING[i] sets on rise, or on an SWTRIG write with bit i=1. It clears on a W1C write or on ACK while vector i+1 is presented.
  - Level channel: PENDING[i] = s2[i] each cycle. W1C and ACK have no effect; software clears the source.
  - Priority order: set beats clear in the same cycle (hardware rise or SWTRIG vs W1C/ACK). A new edge is never lost.
- Candidate: lowest i with PENDING[i] & ENABLE[i].
- Register map (CFG_ADRS), all fields NUM_IRQ bits, zero-extended on read, upper write bits ignored:
  - 0: ENABLE, RW.
  - 1: EDGE, RW.
  - 2: PENDING, read; write-1-to-clear.
  - 3: SWTRIG, write-only (sets pending on edge channels; ignored for level channels); reads 0.
  - Writes take effect on the edge where CFG_WR=1.
- State machine (2 bits):
  - IDLE: VECTOR=0. If a candidate exists, go to PRESENT and register VECTOR=candidate+1.
  - PRESENT: VECTOR held stable; no preemption by higher priority. ACK=1 → BLANK, VECTOR=0. If the presented channel's PENDING&ENABLE drops without ACK (withdrawn, disabled, W1C) → IDLE, VECTOR=0.
  - BLANK: one cycle with VECTOR=0 so the core sees a falling vector; then → IDLE (re-arbitrate next edge).
  - ACK is ignored in IDLE and BLANK.
- Latency: IRQ high before edge e0 (edge mode, enabled, IDLE):
  - s1 at e0, s2 at e1.
  - PENDING at e2.
  - VECTOR nonzero after e3.
  - ACK sampled at edge ek gives VECTOR=0 after ek; earliest next vector after ek+2.
- Boundary cases:
  - NUM_IRQ < 2**VEC_W is enforced by an elaboration check.
  - Simultaneous rises on multiple channels: all latch pending; they are served in priority order over successive ACKs.
  - Rise on the presented channel in the same cycle as ACK: pending stays set and is re-presented after BLANK.

Test Plan:
- Reset: RESET_N low mid-PRESENT with VECTOR=3 → VECTOR=0 immediately, all CFG reads 0; after release, no vector until ENABLE written.
- Edge latency: ENABLE=0x10, EDGE=0x10, IRQ[4] rises before e0 → VECTOR=5 after e3; ACK at e6 → VECTOR=0 after e6, PENDING reads 0.
- Priority/no-preempt: IRQ[6] presented (VECTOR=7), then IRQ[1] rises → VECTOR stays 7 until ACK, one BLANK cycle, then VECTOR=2.
- Level mode: EDGE=0, ENABLE=0x1, IRQ[0] held high → VECTOR=1, re-presented after each ACK+BLANK; IRQ[0] low without ACK → VECTOR=0 within 3 edges.
- Set-vs-clear: W1C of PENDING bit 2 and SWTRIG-equivalent rise on channel 2 in the same cycle → PENDING[2]=1. Likewise, a rise coincident with ACK of vector 3 → vector 3 re-presented after BLANK.
- Withdraw: VECTOR=4 presented, write ENABLE bit3=0 → VECTOR=0 next edge, state IDLE, PENDING[3] still 1.
